// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BLANK_CODE = 4'hE;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-hot anode pattern for the selected digit.
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_mux_tick_gen.sv
// Prescaler counting 0..DIV-1; tick is a registered flag high while the count is DIV-1.
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Registering the comparison against the next count keeps tick aligned with count DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit hex display scanner: hold register, digit rotation, ghost guard and
// leading-zero blanking, all outputs registered with one cycle of latency.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int          REFRESH_DIV   = 50000,
    parameter logic [15:0] LOAD_ON_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  digit_hex,
    output logic [3:0]  an,
    output logic        scan_tick
);

    logic [15:0]           hold_q;
    logic [15:0]           hold_d;
    digit_idx_t            index_q;
    digit_idx_t            index_d;
    logic                  adv_q;
    logic                  tick;
    logic [3:0]            an_q;
    logic [3:0]            an_d;
    logic [3:0]            digit_q;
    logic [3:0]            digit_d;
    logic [3:0]            nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_flag;

    tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A digit is a leading zero when it and every more significant nibble are zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble[gi] = hold_q[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign blank_flag[gi] = 1'b0;
            end else begin : g_upper
                assign blank_flag[gi] = blank_lz && (hold_q[15:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        hold_d  = load ? value_in : hold_q;
        index_d = tick ? index_q + 1'b1 : index_q;
        digit_d = blank_flag[index_q] ? BLANK_CODE : nibble[index_q];
        an_d    = adv_q ? ANODES_OFF : anode_for(index_q);
    end

    // adv_q marks the first cycle of a new slot so its output cycle is dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= LOAD_ON_RESET;
            index_q <= '0;
            adv_q   <= 1'b0;
            an_q    <= ANODES_OFF;
            digit_q <= 4'h0;
        end else begin
            hold_q  <= hold_d;
            index_q <= index_d;
            adv_q   <= tick;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    assign digit_hex = digit_q;
    assign an        = an_q;
    assign scan_tick = tick;

endmodule
